// File: rtl/irq_sched_pkg.sv
// ============================================================================
// Module      : irq_sched_pkg
// Description : Shared constants, types and helpers for the interrupt
//               scheduler (3 buses x 9 channels).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_sched_pkg;

    localparam int NCH  = 9;    // channels per bus
    localparam int NBUS = 3;    // buses A/B/C
    localparam int CW   = 4;    // channel index width
    localparam int TMO  = 255;  // PRESENT cycles without ack before timeout
    localparam int TW   = 8;    // timeout counter width

    localparam logic [1:0]    BUS_A    = 2'd0;
    localparam logic [1:0]    BUS_B    = 2'd1;
    localparam logic [1:0]    BUS_C    = 2'd2;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
    localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    typedef logic [NBUS-1:0][NCH-1:0] pend_t;

    // Next bus in the circular order A -> B -> C -> A
    function automatic logic [1:0] bus_inc(input logic [1:0] b);
        return (b == BUS_C) ? BUS_A : (b + 2'd1);
    endfunction

    // Index of the lowest set bit; 0 when no bit is set
    function automatic logic [CW-1:0] lowest_idx(input logic [NCH-1:0] v);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CW'(i);
            end
        end
        return idx;
    endfunction

    // One-hot {C,B,A} to bus index
    function automatic logic [1:0] bus_idx(input logic [NBUS-1:0] oh);
        logic [1:0] b;
        if (oh[BUS_C]) begin
            b = BUS_C;
        end else if (oh[BUS_B]) begin
            b = BUS_B;
        end else begin
            b = BUS_A;
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_pick.sv
// ============================================================================
// Module      : irq_prio_pick
// Description : Combinational winner selection. Buses are scanned starting
//               at start_bus and wrapping; inside a bus the lowest channel
//               index wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_pick
    import irq_sched_pkg::*;
(
    input  pend_t              eligible,
    input  logic [1:0]         start_bus,
    output logic               any,
    output logic [NBUS-1:0]    bus,
    output logic [CW-1:0]      chan
);

    logic [1:0] sel;

    // Walk the buses in priority order and stop at the first non-empty one
    always_comb begin
        any  = 1'b0;
        bus  = '0;
        chan = '0;
        sel  = (start_bus > BUS_C) ? BUS_A : start_bus;
        for (int k = 0; k < NBUS; k++) begin
            if (!any && (|eligible[sel])) begin
                any      = 1'b1;
                bus[sel] = 1'b1;
                chan     = lowest_idx(eligible[sel]);
            end
            sel = bus_inc(sel);
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_sched_ctrl.sv
// ============================================================================
// Module      : irq_sched_ctrl
// Description : Interrupt scheduler. Latches request pulses into sticky
//               pending bits, masks them with a shared channel enable,
//               presents one winner on a valid/ack handshake and clears it
//               on acknowledge. A presentation that is not acknowledged
//               within TMO cycles is withdrawn with an irq_tmo pulse.
//               Build option IRQ_SCHED_ROUND_ROBIN_EN rotates the starting
//               bus after every acknowledged grant; without it the bus
//               order is fixed A > B > C.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_sched_ctrl
    import irq_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  req_a,
    input  logic [NCH-1:0]  req_b,
    input  logic [NCH-1:0]  req_c,
    input  logic [NCH-1:0]  chan_en,
    input  logic            clr_all,
    input  logic            irq_ack,
    output logic            irq_valid,
    output logic [NBUS-1:0] irq_bus,
    output logic [CW-1:0]   irq_chan,
    output logic            irq_tmo
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    pend_t            pend_q, pend_d;
    logic             valid_q, valid_d;
    logic [NBUS-1:0]  bus_q, bus_d;
    logic [CW-1:0]    chan_q, chan_d;
    logic             tmo_q, tmo_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    pend_t            w_req;
    pend_t            w_eligible;
    pend_t            w_clr_mask;
    logic [1:0]       w_start_bus;
    logic             w_pick_any;
    logic [NBUS-1:0]  w_pick_bus;
    logic [CW-1:0]    w_pick_chan;
    logic             w_ack;
    logic             w_timeout;
    logic [1:0]       w_grant_idx;
    logic [NCH-1:0]   w_one;

    assign w_req       = {req_c, req_b, req_a};
    assign w_one       = {{(NCH-1){1'b0}}, 1'b1};
    assign w_grant_idx = bus_idx(bus_q);

    // Acks only count while presenting; clr_all overrides everything
    assign w_ack     = (state_q == PRESENT) && irq_ack && !clr_all;
    assign w_timeout = (state_q == PRESENT) && !irq_ack && !clr_all
                       && (tmo_cnt_q == TMO_LAST);

    generate
        for (genvar b = 0; b < NBUS; b++) begin : g_elig
            assign w_eligible[b] = pend_q[b] & chan_en;
        end
    endgenerate

`ifdef IRQ_SCHED_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    assign w_start_bus = rr_ptr_q;

    // Round-robin pointer: follows acknowledged grants, cleared by clr_all
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (clr_all) begin
            rr_ptr_d = BUS_A;
        end else if (w_ack) begin
            rr_ptr_d = bus_inc(w_grant_idx);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= BUS_A;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign w_start_bus = BUS_A;
`endif

    irq_prio_pick u_pick (
        .eligible  (w_eligible),
        .start_bus (w_start_bus),
        .any       (w_pick_any),
        .bus       (w_pick_bus),
        .chan      (w_pick_chan)
    );

    // Pending bits: new requests always win over a same-edge clear
    always_comb begin
        w_clr_mask = '0;
        if (clr_all) begin
            w_clr_mask = '1;
        end else if (w_ack) begin
            w_clr_mask[w_grant_idx] = w_one << chan_q;
        end
        pend_d = (pend_q & ~w_clr_mask) | w_req;
    end

    // FSM state register and all datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            valid_q   <= 1'b0;
            bus_q     <= '0;
            chan_q    <= '0;
            tmo_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            bus_q     <= bus_d;
            chan_q    <= chan_d;
            tmo_q     <= tmo_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // FSM next state: IDLE -> PRESENT -> GAP -> IDLE, clr_all forces IDLE
    always_comb begin
        state_d = state_q;
        if (clr_all) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = w_pick_any ? PRESENT : IDLE;
                PRESENT: state_d = (w_ack || w_timeout) ? GAP : PRESENT;
                GAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: winner is captured on entry to PRESENT and held until exit
    always_comb begin
        valid_d   = valid_q;
        bus_d     = bus_q;
        chan_d    = chan_q;
        tmo_d     = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        if (clr_all) begin
            valid_d   = 1'b0;
            bus_d     = '0;
            chan_d    = '0;
            tmo_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_pick_any) begin
                        valid_d   = 1'b1;
                        bus_d     = w_pick_bus;
                        chan_d    = w_pick_chan;
                        tmo_cnt_d = '0;
                    end
                end
                PRESENT: begin
                    if (w_ack || w_timeout) begin
                        valid_d = 1'b0;
                        bus_d   = '0;
                        chan_d  = '0;
                        tmo_d   = w_timeout;
                    end else if (tmo_cnt_q != CNT_MAX) begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    bus_d   = '0;
                    chan_d  = '0;
                end
            endcase
        end
    end

    assign irq_valid = valid_q;
    assign irq_bus   = bus_q;
    assign irq_chan  = chan_q;
    assign irq_tmo   = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_sched_ctrl.sv
// ============================================================================
// Module      : tb_irq_sched_ctrl
// Description : Self-checking bench for irq_sched_ctrl. Directed scenarios
//               followed by random traffic, all compared every cycle with a
//               behavioural reference model. Honours IRQ_SCHED_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_sched_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] req_a = '0, req_b = '0, req_c = '0;
    logic [8:0] chan_en = 9'h1FF;
    logic       clr_all = 1'b0, irq_ack = 1'b0;
    logic       irq_valid;
    logic [2:0] irq_bus;
    logic [3:0] irq_chan;
    logic       irq_tmo;

    int n_assert = 0;
    int n_fail   = 0;

    irq_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .chan_en   (chan_en),
        .clr_all   (clr_all),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_bus   (irq_bus),
        .irq_chan  (irq_chan),
        .irq_tmo   (irq_tmo)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_pend [3][9];
    bit m_valid, m_tmo;
    int m_bus, m_chan;
    int m_phase;      // 0 idle, 1 presenting, 2 gap
    int m_wait;       // cycles spent presenting, saturating at 255
    int m_rr;

    task automatic model_reset();
        foreach (m_pend[b, i]) m_pend[b][i] = 1'b0;
        m_valid = 0; m_tmo = 0; m_bus = 0; m_chan = 0;
        m_phase = 0; m_wait = 0; m_rr = 0;
    endtask

    task automatic model_edge(input logic [8:0] ra, rb, rc, en,
                              input logic clr, ack);
        logic [8:0] req [3];
        int start, b;
        bit found;
        req[0] = ra; req[1] = rb; req[2] = rc;
        m_tmo = 0;
        if (clr) begin
            foreach (m_pend[bb, i]) m_pend[bb][i] = req[bb][i];
            m_valid = 0; m_phase = 0; m_wait = 0; m_rr = 0;
            return;
        end
        if (m_phase == 0) begin
`ifdef IRQ_SCHED_ROUND_ROBIN_EN
            start = m_rr;
`else
            start = 0;
`endif
            found = 0;
            for (int k = 0; k < 3 && !found; k++) begin
                b = (start + k) % 3;
                for (int i = 0; i < 9 && !found; i++) begin
                    if (m_pend[b][i] && en[i]) begin
                        found = 1; m_bus = b; m_chan = i;
                    end
                end
            end
            if (found) begin
                m_valid = 1; m_phase = 1; m_wait = 0;
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                m_pend[m_bus][m_chan] = 1'b0;
                m_rr = (m_bus + 1) % 3;
                m_valid = 0; m_phase = 2;
            end else if (m_wait == 254) begin
                m_tmo = 1; m_valid = 0; m_phase = 2;
            end else if (m_wait < 255) begin
                m_wait++;
            end
        end else begin
            m_phase = 0;
        end
        foreach (m_pend[bb, i]) m_pend[bb][i] = m_pend[bb][i] | req[bb][i];
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(irq_valid), 32'(m_valid));
        chk({tag, ".bus"},   32'(irq_bus),   m_valid ? (32'd1 << m_bus) : 32'd0);
        chk({tag, ".chan"},  32'(irq_chan),  m_valid ? 32'(m_chan) : 32'd0);
        chk({tag, ".tmo"},   32'(irq_tmo),   32'(m_tmo));
    endtask

    // One clock: drive inputs, advance model on the edge, compare after it
    task automatic cyc(input logic [8:0] ra, rb, rc, input logic clr, ack);
        req_a = ra; req_b = rb; req_c = rc; clr_all = clr; irq_ack = ack;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(ra, rb, rc, chan_en, clr, ack);
        #1;
        check_model("cyc");
        req_a = '0; req_b = '0; req_c = '0; clr_all = 1'b0; irq_ack = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) cyc('0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic ack_and_gap();
        cyc('0, '0, '0, 1'b0, 1'b1);
        idle_n(2);
    endtask

    initial begin
        model_reset();
        req_a = 9'h1FF;
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");

        // 1: all of bus A pending out of reset, drained lowest first
        rst_n = 1'b1;
        cyc(9'h1FF, '0, '0, 1'b0, 1'b0);
        chk("t1.edge1_valid", 32'(irq_valid), 32'd0);
        cyc('0, '0, '0, 1'b0, 1'b0);
        chk("t1.edge2_valid", 32'(irq_valid), 32'd1);
        for (int ch = 0; ch < 9; ch++) begin
            chk("t1.bus",  32'(irq_bus),  32'd1);
            chk("t1.chan", 32'(irq_chan), 32'(ch));
            ack_and_gap();
        end
        chk("t1.drained", 32'(irq_valid), 32'd0);

        // 2: B/3 and C/0 in the same cycle
        cyc('0, 9'h008, 9'h001, 1'b0, 1'b0);
        idle_n(1);
        chk("t2.first_bus",  32'(irq_bus),  32'd2);
        chk("t2.first_chan", 32'(irq_chan), 32'd3);
        ack_and_gap();
        chk("t2.second_bus",  32'(irq_bus),  32'd4);
        chk("t2.second_chan", 32'(irq_chan), 32'd0);
        ack_and_gap();

        // 3: masked channel stays silent until enabled
        chan_en = 9'h1DF;
        cyc(9'h020, '0, '0, 1'b0, 1'b0);
        idle_n(3);
        chk("t3.masked_valid", 32'(irq_valid), 32'd0);
        chan_en = 9'h1FF;
        idle_n(1);
        chk("t3.unmask_valid", 32'(irq_valid), 32'd1);
        chk("t3.unmask_chan",  32'(irq_chan),  32'd5);
        ack_and_gap();

        // 4: timeout after 255 unacknowledged PRESENT cycles
        cyc(9'h004, '0, '0, 1'b0, 1'b0);
        idle_n(1);
        chk("t4.present", 32'(irq_valid), 32'd1);
        idle_n(254);
        chk("t4.still_valid", 32'(irq_valid), 32'd1);
        chk("t4.no_tmo_yet",  32'(irq_tmo),   32'd0);
        idle_n(1);
        chk("t4.tmo_pulse",  32'(irq_tmo),   32'd1);
        chk("t4.valid_drop", 32'(irq_valid), 32'd0);
        idle_n(1);
        chk("t4.tmo_end", 32'(irq_tmo), 32'd0);
        idle_n(1);
        chk("t4.represent_chan", 32'(irq_chan),  32'd2);
        chk("t4.represent_vld",  32'(irq_valid), 32'd1);
        ack_and_gap();

        // 5: ack and new request of the same bit on the same edge
        cyc(9'h010, '0, '0, 1'b0, 1'b0);
        idle_n(1);
        chk("t5.first_chan", 32'(irq_chan), 32'd4);
        cyc(9'h010, '0, '0, 1'b0, 1'b1);
        idle_n(2);
        chk("t5.again_valid", 32'(irq_valid), 32'd1);
        chk("t5.again_chan",  32'(irq_chan),  32'd4);
        ack_and_gap();

        // 6: clr_all mid-presentation, only the same-cycle request survives
        cyc(9'h002, 9'h1FF, '0, 1'b0, 1'b0);
        idle_n(1);
        cyc('0, '0, 9'h100, 1'b1, 1'b0);
        chk("t6.clr_valid", 32'(irq_valid), 32'd0);
        idle_n(1);
        chk("t6.c8_bus",  32'(irq_bus),  32'd4);
        chk("t6.c8_chan", 32'(irq_chan), 32'd8);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6.async_valid", 32'(irq_valid), 32'd0);
        chk("t6.async_bus",   32'(irq_bus),   32'd0);
        chk("t6.async_chan",  32'(irq_chan),  32'd0);
        idle_n(2);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [8:0] ra, rb, rc;
            ra = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h0;
            rb = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h0;
            rc = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h0;
            if ($urandom_range(0, 15) == 0) chan_en = 9'($urandom);
            cyc(ra, rb, rc, $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
